rvb_pcpi_core: RTL and testbench

//  RV32 bit-manipulation coprocessor on the picorv32 PCPI bus. Decodes a Zbb-style subset
//  (logic-with-negate, rotates, min/max, count, sign-extend, optional ternary ops),

---
 rtl/rvb_pcpi_core.sv | 163 ++++++++++++++++
 tb/tb_rvb_pcpi_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rvb_pcpi_core.sv
// Zbb-style bit-manipulation coprocessor on the picorv32 PCPI bus; RVB_TERNARY_EN adds cmix/cmov.
// Latency: result and a one-cycle ready/wr pulse appear the cycle after a recognised insn is sampled.
// Backpressure: none; unrecognised insns are never claimed so the CPU times out and traps.
module rvb_pcpi_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pcpi_valid,
    input  logic [31:0]     pcpi_insn,
    input  logic [XLEN-1:0] pcpi_rs1,
    input  logic [XLEN-1:0] pcpi_rs2,
    input  logic [XLEN-1:0] pcpi_rs3,
    output logic            pcpi_wr,
    output logic [XLEN-1:0] pcpi_rd,
    output logic            pcpi_wait,
    output logic            pcpi_ready
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic {IDLE, DONE} state_t;

    state_t          state, state_nxt;
    logic            rec;
    logic [XLEN-1:0] res;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    logic [4:0] r2f, sh;
    logic [2*XLEN-1:0] rot_l, rot_r;

    assign opc = pcpi_insn[6:0];
    assign f3  = pcpi_insn[14:12];
    assign f7  = pcpi_insn[31:25];
    assign r2f = pcpi_insn[24:20];
    assign sh  = (opc == OPC_OP_IMM) ? r2f : pcpi_rs2[4:0];

    // Rotating a doubled word avoids a special case for a shift amount of zero.
    assign rot_r = {pcpi_rs1, pcpi_rs1} >> sh;
    assign rot_l = {pcpi_rs1, pcpi_rs1} << sh;

    logic unused_bits;
    assign unused_bits = ^{pcpi_insn[19:15], pcpi_insn[11:7], pcpi_rs3};

    function automatic logic [5:0] f_clz(input logic [XLEN-1:0] v);
        logic [5:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = XLEN - 1; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 6'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] f_ctz(input logic [XLEN-1:0] v);
        logic [5:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 6'd1;
            end
        end
        return n;
    endfunction

    function automatic logic [5:0] f_pcnt(input logic [XLEN-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < XLEN; i++) n = n + {5'd0, v[i]};
        return n;
    endfunction

    always_comb begin
        rec = 1'b0;
        res = '0;
        if (opc == OPC_OP) begin
            if (f7 == 7'b0100000) begin
                case (f3)
                    3'b111:  begin rec = 1'b1; res = pcpi_rs1 & ~pcpi_rs2;   end
                    3'b110:  begin rec = 1'b1; res = pcpi_rs1 | ~pcpi_rs2;   end
                    3'b100:  begin rec = 1'b1; res = ~(pcpi_rs1 ^ pcpi_rs2); end
                    default: ;
                endcase
            end else if (f7 == 7'b0110000) begin
                case (f3)
                    3'b001:  begin rec = 1'b1; res = rot_l[2*XLEN-1:XLEN]; end
                    3'b101:  begin rec = 1'b1; res = rot_r[XLEN-1:0];      end
                    default: ;
                endcase
            end else if (f7 == 7'b0000101) begin
                rec = f3[2];
                case (f3)
                    3'b100:  res = ($signed(pcpi_rs1) < $signed(pcpi_rs2)) ? pcpi_rs1 : pcpi_rs2;
                    3'b101:  res = (pcpi_rs1 < pcpi_rs2) ? pcpi_rs1 : pcpi_rs2;
                    3'b110:  res = ($signed(pcpi_rs1) > $signed(pcpi_rs2)) ? pcpi_rs1 : pcpi_rs2;
                    3'b111:  res = (pcpi_rs1 > pcpi_rs2) ? pcpi_rs1 : pcpi_rs2;
                    default: ;
                endcase
`ifdef RVB_TERNARY_EN
            end else if (f7[1:0] == 2'b11) begin
                case (f3)
                    3'b001:  begin rec = 1'b1; res = (pcpi_rs1 & pcpi_rs2) | (pcpi_rs3 & ~pcpi_rs2); end
                    3'b101:  begin rec = 1'b1; res = (pcpi_rs2 != '0) ? pcpi_rs1 : pcpi_rs3;        end
                    default: ;
                endcase
`endif
            end
        end else if (opc == OPC_OP_IMM && f7 == 7'b0110000) begin
            if (f3 == 3'b001) begin
                case (r2f)
                    5'd0:    begin rec = 1'b1; res = {{(XLEN-6){1'b0}}, f_clz(pcpi_rs1)};  end
                    5'd1:    begin rec = 1'b1; res = {{(XLEN-6){1'b0}}, f_ctz(pcpi_rs1)};  end
                    5'd2:    begin rec = 1'b1; res = {{(XLEN-6){1'b0}}, f_pcnt(pcpi_rs1)}; end
                    5'd4:    begin rec = 1'b1; res = {{(XLEN-8){pcpi_rs1[7]}}, pcpi_rs1[7:0]};    end
                    5'd5:    begin rec = 1'b1; res = {{(XLEN-16){pcpi_rs1[15]}}, pcpi_rs1[15:0]}; end
                    default: ;
                endcase
            end else if (f3 == 3'b101) begin
                rec = 1'b1;
                res = rot_r[XLEN-1:0];
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        case (state)
            IDLE: begin
                pcpi_wait = pcpi_valid & rec;
                if (pcpi_valid && rec) state_nxt = DONE;
            end
            DONE: begin
                pcpi_ready = 1'b1;
                pcpi_wr    = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pcpi_rd <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pcpi_valid && rec) pcpi_rd <= res;
        end
    end

endmodule

// File: tb/tb_rvb_pcpi_core.sv
// Randomised scoreboard bench for rvb_pcpi_core against an instruction-level reference model.
module tb_rvb_pcpi_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pcpi_valid = 1'b0;
    logic [31:0] pcpi_insn = '0, pcpi_rs1 = '0, pcpi_rs2 = '0, pcpi_rs3 = '0;
    logic        pcpi_wr, pcpi_wait, pcpi_ready;
    logic [31:0] pcpi_rd;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] expq[$];

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;

    rvb_pcpi_core #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_rs3(pcpi_rs3),
        .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] r2,
                                       input logic [2:0] f3, input logic [6:0] opc);
        return {f7, r2, 5'd0, f3, 5'd0, opc};
    endfunction

    // Reference model: decodes by field and computes with bit-serial loops and plain arithmetic.
    task automatic model(input logic [31:0] i, a, b, c, output logic ok, output logic [31:0] r);
        logic [6:0] f7;
        logic [2:0] f3;
        int         amt;
        f7 = i[31:25];
        f3 = i[14:12];
        ok = 1'b0;
        r  = '0;
        if (i[6:0] == OP) begin
            if (f7 == 7'h20 && f3 == 3'd7)      begin ok = 1; r = a & ~b; end
            else if (f7 == 7'h20 && f3 == 3'd6) begin ok = 1; r = a | ~b; end
            else if (f7 == 7'h20 && f3 == 3'd4) begin ok = 1; r = ~(a ^ b); end
            else if (f7 == 7'h30 && (f3 == 3'd1 || f3 == 3'd5)) begin
                ok = 1; r = a; amt = b % 32;
                repeat (amt) r = (f3 == 3'd1) ? {r[30:0], r[31]} : {r[0], r[31:1]};
            end else if (f7 == 7'h05 && f3 >= 3'd4) begin
                ok = 1;
                case (f3)
                    3'd4:    r = (int'(a) < int'(b)) ? a : b;
                    3'd5:    r = (a < b) ? a : b;
                    3'd6:    r = (int'(a) < int'(b)) ? b : a;
                    default: r = (a < b) ? b : a;
                endcase
            end
`ifdef RVB_TERNARY_EN
            else if (i[26:25] == 2'b11 && f3 == 3'd1) begin ok = 1; r = (a & b) | (c & ~b); end
            else if (i[26:25] == 2'b11 && f3 == 3'd5) begin ok = 1; r = (b != 0) ? a : c; end
`endif
        end else if (i[6:0] == IMM && f7 == 7'h30) begin
            amt = int'(i[24:20]);
            if (f3 == 3'd5) begin
                ok = 1; r = a;
                repeat (amt) r = {r[0], r[31:1]};
            end else if (f3 == 3'd1) begin
                int n;
                n = 0;
                case (amt)
                    0: begin ok = 1; while (n < 32 && a[31-n] == 1'b0) n++; r = n; end
                    1: begin ok = 1; while (n < 32 && a[n] == 1'b0) n++; r = n; end
                    2: begin ok = 1; for (int k = 0; k < 32; k++) n += int'(a[k]); r = n; end
                    4: begin ok = 1; r = int'($signed(a[7:0])); end
                    5: begin ok = 1; r = int'($signed(a[15:0])); end
                    default: ;
                endcase
            end
        end
    endtask

    // Presents one instruction for one cycle; the expectation goes on the scoreboard.
    task automatic issue_x(input logic [31:0] i, a, b, c, input logic ok, input logic [31:0] r,
                           input string nm);
        @(posedge clk); #1;
        pcpi_insn = i; pcpi_rs1 = a; pcpi_rs2 = b; pcpi_rs3 = c; pcpi_valid = 1'b1;
        @(negedge clk);
        check({nm, " wait"}, {31'd0, pcpi_wait}, {31'd0, ok});
        if (ok) expq.push_back(r);
        @(posedge clk); #1;
        pcpi_valid = 1'b0;
        @(negedge clk);
        check({nm, " ready"}, {31'd0, pcpi_ready}, {31'd0, ok});
    endtask

    task automatic issue(input logic [31:0] i, a, b, c, input string nm);
        logic        ok;
        logic [31:0] r;
        model(i, a, b, c, ok, r);
        issue_x(i, a, b, c, ok, r, nm);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 4))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000 >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset === 1'b0 && pcpi_ready === 1'b1) begin
            if (expq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ready: got ready=1 rd=%h expected no ready", pcpi_rd);
            end else begin
                check("rd", pcpi_rd, expq.pop_front());
                check("wr_with_ready", {31'd0, pcpi_wr}, 32'd1);
                check("wait_not_with_ready", {31'd0, pcpi_wait}, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] i;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ready", {31'd0, pcpi_ready}, 32'd0);
        check("reset wr", {31'd0, pcpi_wr}, 32'd0);
        check("reset rd", pcpi_rd, 32'd0);
        check("reset wait", {31'd0, pcpi_wait}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        issue_x(mk(7'h20, 0, 7, OP), 32'hFF00FF00, 32'h0F0F0F0F, 0, 1, 32'hF000F000, "andn");
        issue_x(mk(7'h30, 0, 5, OP), 32'h12345678, 32'd8, 0, 1, 32'h78123456, "ror8");
        issue_x(mk(7'h30, 0, 5, IMM), 32'h12345678, 0, 0, 1, 32'h12345678, "rori0");
        issue_x(mk(7'h30, 0, 1, OP), 32'h12345678, 32'd4, 0, 1, 32'h23456781, "rol4");
        issue_x(mk(7'h30, 0, 1, IMM), 32'h00010000, 0, 0, 1, 32'd15, "clz");
        issue_x(mk(7'h30, 0, 1, IMM), 32'h0, 0, 0, 1, 32'd32, "clz0");
        issue_x(mk(7'h30, 1, 1, IMM), 32'h80000000, 0, 0, 1, 32'd31, "ctz");
        issue_x(mk(7'h30, 1, 1, IMM), 32'h0, 0, 0, 1, 32'd32, "ctz0");
        issue_x(mk(7'h30, 2, 1, IMM), 32'hF0F0F0F0, 0, 0, 1, 32'd16, "pcnt");
        issue_x(mk(7'h05, 0, 4, OP), 32'hFFFFFFFF, 32'd1, 0, 1, 32'hFFFFFFFF, "min");
        issue_x(mk(7'h05, 0, 5, OP), 32'hFFFFFFFF, 32'd1, 0, 1, 32'h1, "minu");
        issue_x(mk(7'h05, 0, 6, OP), 32'hFFFFFFFF, 32'd1, 0, 1, 32'h1, "max");
        issue_x(mk(7'h05, 0, 7, OP), 32'hFFFFFFFF, 32'd1, 0, 1, 32'hFFFFFFFF, "maxu");
        issue_x(mk(7'h30, 4, 1, IMM), 32'h00000080, 0, 0, 1, 32'hFFFFFF80, "sextb");
        issue_x(mk(7'h30, 5, 1, IMM), 32'h00007FFF, 0, 0, 1, 32'h00007FFF, "sexth");
        issue_x(mk(7'h30, 3, 1, IMM), 32'h12345678, 0, 0, 0, 32'h0, "imm_rs2_3");
`ifdef RVB_TERNARY_EN
        issue_x(mk(7'h03, 0, 1, OP), 32'h12345678, 32'hFFFF0000, 32'hAAAAAAAA, 1, 32'h1234AAAA, "cmix");
`else
        issue_x(mk(7'h03, 0, 1, OP), 32'h12345678, 32'hFFFF0000, 32'hAAAAAAAA, 0, 32'h0, "cmix_off");
`endif

        // Unrecognised instruction held for 20 cycles is never claimed.
        @(posedge clk); #1;
        pcpi_insn = mk(7'h04, 0, 0, OP); pcpi_rs1 = $urandom; pcpi_rs2 = $urandom; pcpi_valid = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("unrec wait", {31'd0, pcpi_wait}, 32'd0);
            check("unrec wr", {31'd0, pcpi_wr}, 32'd0);
        end
        @(posedge clk); #1 pcpi_valid = 1'b0;

        // Valid held across DONE is taken again as a second request.
        @(posedge clk); #1;
        pcpi_insn = mk(7'h20, 0, 7, OP); pcpi_rs1 = 32'hA5A5A5A5; pcpi_rs2 = 32'h0000FFFF;
        pcpi_valid = 1'b1;
        expq.push_back(32'hA5A50000);
        expq.push_back(32'hA5A50000);
        @(posedge clk);
        @(negedge clk);
        check("held done wait", {31'd0, pcpi_wait}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("held redecode wait", {31'd0, pcpi_wait}, 32'd1);
        @(posedge clk); #1 pcpi_valid = 1'b0;
        @(posedge clk);

        // Reset coinciding with the accept edge drops the result.
        @(posedge clk); #1;
        pcpi_insn = mk(7'h20, 0, 6, OP); pcpi_rs1 = 32'h1; pcpi_rs2 = 32'h2;
        pcpi_valid = 1'b1; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; pcpi_valid = 1'b0;
        @(negedge clk);
        check("rst accept ready", {31'd0, pcpi_ready}, 32'd0);
        check("rst accept rd", pcpi_rd, 32'd0);

        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 17))
                0:  i = mk(7'h20, 0, 7, OP);
                1:  i = mk(7'h20, 0, 6, OP);
                2:  i = mk(7'h20, 0, 4, OP);
                3:  i = mk(7'h30, 0, 1, OP);
                4:  i = mk(7'h30, 0, 5, OP);
                5:  i = mk(7'h05, 0, 4, OP);
                6:  i = mk(7'h05, 0, 5, OP);
                7:  i = mk(7'h05, 0, 6, OP);
                8:  i = mk(7'h05, 0, 7, OP);
                9:  i = mk(7'h30, 5'($urandom_range(0, 31)), 5, IMM);
                10: i = mk(7'h30, 5'($urandom_range(0, 7)), 1, IMM);
                11: i = mk(7'h30, 0, 1, IMM);
                12: i = mk(7'h30, 1, 1, IMM);
                13: i = mk({5'($urandom), 2'b11}, 0, 1, OP);
                14: i = mk({5'($urandom), 2'b11}, 0, 5, OP);
                15: i = mk(7'h20, 0, 3'($urandom), OP);
                16: i = mk(7'($urandom), 5'($urandom), 3'($urandom), ($urandom_range(0, 1) == 1) ? OP : IMM);
                default: i = $urandom;
            endcase
            i = i | ($urandom & 32'h000F8F80);
            issue(i, rnd_val(), (($urandom_range(0, 3) == 0) ? 32'd0 : rnd_val()), rnd_val(), "rnd");
        end

        repeat (4) @(posedge clk);
        check("scoreboard drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
